matrix_loader: RTL and testbench

Upstream feeder for the 3x3 `matrix` multiplier. It accepts a serial byte stream under a valid/ready handshake, assembles 18 elements (A row-major, then B row-major) in a shadow buffer, and transfers a complete frame to its parallel outputs. On transfer it pulses `Load` for one cycle. It then paces the multiplier with a programmable hold window, and it prefetches the next frame while the current one is held.

---
 rtl/matrix_loader_if.sv | 37 +++
 rtl/matrix_loader.sv | 119 +++++++++++
 tb/tb_matrix_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// matrix_loader_if: byte-stream input handshake plus the parallel 3x3 A/B
// frame outputs and status strobes of matrix_loader.
//   in_data/in_valid/in_last : element stream from the producer (master)
//   in_ready                 : loader can take an element this cycle
//   A00..A22, B00..B22       : registered frame outputs, row-major naming
//   Load                     : one-cycle strobe, outputs hold a new frame
//   busy                     : hold window active
//   frame_err                : one-cycle pulse, malformed frame dropped
interface matrix_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    logic [7:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
    logic [7:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;

    logic       Load;
    logic       busy;
    logic       frame_err;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  A00, A01, A02, A10, A11, A12, A20, A21, A22,
        input  B00, B01, B02, B10, B11, B12, B20, B21, B22,
        input  Load, busy, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output A00, A01, A02, A10, A11, A12, A20, A21, A22,
        output B00, B01, B02, B10, B11, B12, B20, B21, B22,
        output Load, busy, frame_err
    );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: assembles an 18-element frame (A row-major, then B
// row-major) from a valid/ready byte stream into a shadow buffer and moves a
// complete frame to the parallel A/B outputs, pulsing Load. After a transfer
// the outputs are held for HOLD_CYCLES cycles (busy high); the next frame's
// first 17 elements may be prefetched meanwhile, only its final element is
// stalled until the hold window has expired.
// Ports:
//   clk   : system clock, rising edge
//   Reset : asynchronous, active-high reset
//   bus   : matrix_loader_if slave modport (stream in, frame/status out)
// Parameters:
//   HOLD_CYCLES : hold window length including the Load cycle, 1..255
module matrix_loader #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic            clk,
    input  logic            Reset,
    matrix_loader_if.slave  bus
);

    localparam logic [4:0] LAST_IDX = 5'd17;

    logic [4:0] idx_q,  idx_d;
    logic [7:0] hold_q, hold_d;
    // Only 17 shadow slots: the 18th element goes straight from in_data to
    // the outputs on the completing edge.
    logic [7:0] shadow_q [17];
    logic [7:0] shadow_d [17];
    logic [7:0] out_q [18];
    logic [7:0] out_d [18];
    logic       load_q, load_d;
    logic       err_q,  err_d;
    logic       ready;
    logic       accept;

    always_comb begin
        ready    = !Reset && !(idx_q == LAST_IDX && hold_q != '0);
        accept   = bus.in_valid && ready;

        idx_d    = idx_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        hold_d   = (hold_q != '0) ? hold_q - 8'd1 : '0;

        if (accept) begin
            if (idx_q != LAST_IDX) begin
                if (bus.in_last) begin
                    // Early end: drop frame, partial shadow is overwritten later.
                    err_d = 1'b1;
                    idx_d = '0;
                end else begin
                    for (int unsigned i = 0; i < 17; i++) begin
                        if (idx_q == 5'(i)) begin
                            shadow_d[i] = bus.in_data;
                        end
                    end
                    idx_d = idx_q + 5'd1;
                end
            end else if (bus.in_last) begin
                for (int unsigned i = 0; i < 17; i++) begin
                    out_d[i] = shadow_q[i];
                end
                out_d[17] = bus.in_data;
                idx_d     = '0;
                hold_d    = 8'(HOLD_CYCLES);
                load_d    = 1'b1;
            end else begin
                // Missing end marker on the 18th element.
                err_d = 1'b1;
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            idx_q    <= '0;
            hold_q   <= '0;
            shadow_q <= '{default: '0};
            out_q    <= '{default: '0};
            load_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            load_q   <= load_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.Load      = load_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (hold_q != '0);

    assign bus.A00 = out_q[0];
    assign bus.A01 = out_q[1];
    assign bus.A02 = out_q[2];
    assign bus.A10 = out_q[3];
    assign bus.A11 = out_q[4];
    assign bus.A12 = out_q[5];
    assign bus.A20 = out_q[6];
    assign bus.A21 = out_q[7];
    assign bus.A22 = out_q[8];
    assign bus.B00 = out_q[9];
    assign bus.B01 = out_q[10];
    assign bus.B02 = out_q[11];
    assign bus.B10 = out_q[12];
    assign bus.B11 = out_q[13];
    assign bus.B12 = out_q[14];
    assign bus.B20 = out_q[15];
    assign bus.B21 = out_q[16];
    assign bus.B22 = out_q[17];

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: two loaders (HOLD_CYCLES 8 and 32) driven by independent
// stimulus, each compared every falling edge against a frame-level model of
// the loader (element list, element count, remaining hold cycles).
module tb_matrix_loader;

    localparam int unsigned HOLD0 = 8;
    localparam int unsigned HOLD1 = 32;

    logic       clk;
    logic       rst     [2];
    logic [7:0] v_data  [2];
    logic       v_valid [2];
    logic       v_last  [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    matrix_loader_if if0 ();
    matrix_loader_if if1 ();

    assign if0.in_data  = v_data[0];
    assign if0.in_valid = v_valid[0];
    assign if0.in_last  = v_last[0];
    assign if1.in_data  = v_data[1];
    assign if1.in_valid = v_valid[1];
    assign if1.in_last  = v_last[1];

    matrix_loader #(.HOLD_CYCLES(HOLD0)) dut0 (.clk(clk), .Reset(rst[0]), .bus(if0));
    matrix_loader #(.HOLD_CYCLES(HOLD1)) dut1 (.clk(clk), .Reset(rst[1]), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] d_out   [2][18];
    logic       d_load  [2];
    logic       d_busy  [2];
    logic       d_err   [2];
    logic       d_ready [2];

    always_comb begin
        d_out[0] = '{if0.A00, if0.A01, if0.A02, if0.A10, if0.A11, if0.A12, if0.A20, if0.A21, if0.A22,
                     if0.B00, if0.B01, if0.B02, if0.B10, if0.B11, if0.B12, if0.B20, if0.B21, if0.B22};
        d_out[1] = '{if1.A00, if1.A01, if1.A02, if1.A10, if1.A11, if1.A12, if1.A20, if1.A21, if1.A22,
                     if1.B00, if1.B01, if1.B02, if1.B10, if1.B11, if1.B12, if1.B20, if1.B21, if1.B22};
        d_load[0] = if0.Load;  d_busy[0] = if0.busy;  d_err[0] = if0.frame_err;  d_ready[0] = if0.in_ready;
        d_load[1] = if1.Load;  d_busy[1] = if1.busy;  d_err[1] = if1.frame_err;  d_ready[1] = if1.in_ready;
    end

    // ---------------- frame-level model ----------------
    logic [7:0] m_elem [2][18];   // elements of the frame under assembly
    logic [7:0] m_out  [2][18];   // frame currently presented
    int         m_cnt  [2];       // elements collected so far
    int         m_hold [2];       // hold cycles remaining
    logic       m_load [2];
    logic       m_err  [2];

    function automatic int hold_of(input int k);
        return (k == 0) ? int'(HOLD0) : int'(HOLD1);
    endfunction

    function automatic logic m_ready(input int k);
        return !rst[k] && !(m_cnt[k] == 17 && m_hold[k] != 0);
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < 18; i++) begin
            m_elem[k][i] = 8'h00;
            m_out[k][i]  = 8'h00;
        end
        m_cnt[k]  = 0;
        m_hold[k] = 0;
        m_load[k] = 1'b0;
        m_err[k]  = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic nl, ne;
        int   nh;
        nl = 1'b0;
        ne = 1'b0;
        nh = (m_hold[k] > 0) ? m_hold[k] - 1 : 0;
        if (v_valid[k] && m_ready(k)) begin
            m_elem[k][m_cnt[k]] = v_data[k];
            if (m_cnt[k] == 17 && v_last[k]) begin
                for (int i = 0; i < 18; i++) m_out[k][i] = m_elem[k][i];
                nl = 1'b1;
                nh = hold_of(k);
                m_cnt[k] = 0;
            end else if (m_cnt[k] == 17 || v_last[k]) begin
                ne = 1'b1;
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        m_load[k] = nl;
        m_err[k]  = ne;
        m_hold[k] = nh;
    endtask

    function automatic logic [143:0] pack_dut(input int k);
        logic [143:0] p;
        for (int i = 0; i < 18; i++) p[i*8 +: 8] = d_out[k][i];
        return p;
    endfunction

    function automatic logic [143:0] pack_model(input int k);
        logic [143:0] p;
        for (int i = 0; i < 18; i++) p[i*8 +: 8] = m_out[k][i];
        return p;
    endfunction

    task automatic check(input string name, input int k, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    // Per-cycle compare, then advance the model with the inputs the DUT
    // will sample at the coming rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) model_clear(k);
            check("outputs", k, pack_dut(k), pack_model(k));
            check("ctl{load,busy,err,ready}", k,
                  144'({d_load[k], d_busy[k], d_err[k], d_ready[k]}),
                  144'({m_load[k], (m_hold[k] != 0), m_err[k], m_ready(k)}));
            if (!rst[k]) model_step(k);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] fb [2][18];
    int         stall1 = 0;
    int         load_t1 [$];

    always @(negedge clk) begin
        if (d_busy[1] && !d_ready[1] && v_valid[1]) stall1++;
        if (d_load[1]) load_t1.push_back(cyc);
    end

    // All tasks start and end at posedge+1.
    task automatic send_byte(input int k, input logic [7:0] d, input logic last, input logic gaps);
        int   n;
        logic done, acc;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            v_data[k]  = d;
            v_last[k]  = last;
            v_valid[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = v_valid[k] && d_ready[k];
            @(posedge clk);
            #1;
            done = acc;
            n++;
        end
        v_valid[k] = 1'b0;
        v_last[k]  = 1'b0;
        if (!done) check("accept_timeout", k, 144'(done), 144'(1));
    endtask

    task automatic send_frame(input int k, input int n, input int last_at, input logic gaps);
        for (int i = 0; i < n; i++) send_byte(k, fb[k][i], (i == last_at), gaps);
    endtask

    task automatic fill_rand(input int k);
        for (int i = 0; i < 18; i++) fb[k][i] = 8'($urandom);
    endtask

    task automatic observe(input int k, input int n, output int loads, output int busys, output int errs);
        loads = 0; busys = 0; errs = 0;
        repeat (n) begin
            @(negedge clk);
            if (d_load[k]) loads++;
            if (d_busy[k]) busys++;
            if (d_err[k])  errs++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input int k);
        #2 rst[k] = 1'b1;
        #1;
        check("async_reset_outputs", k, pack_dut(k), '0);
        check("async_reset_ctl", k, 144'({d_load[k], d_busy[k], d_err[k], d_ready[k]}), '0);
        @(negedge clk);
        @(posedge clk);
        #1 rst[k] = 1'b0;
    endtask

    // ---------------- test sequences ----------------
    task automatic run_dut0();
        int lds, bsy, ers;

        // single frame
        fb[0][0] = 8'h24;
        for (int i = 1; i < 9; i++)  fb[0][i] = 8'h20;
        for (int i = 9; i < 18; i++) fb[0][i] = 8'h28;
        send_frame(0, 18, 17, 1'b0);
        check("single_A00", 0, 144'(d_out[0][0]),  144'(8'h24));
        check("single_A01", 0, 144'(d_out[0][1]),  144'(8'h20));
        check("single_A22", 0, 144'(d_out[0][8]),  144'(8'h20));
        check("single_B00", 0, 144'(d_out[0][9]),  144'(8'h28));
        check("single_B22", 0, 144'(d_out[0][17]), 144'(8'h28));
        observe(0, 24, lds, bsy, ers);
        check("single_load_cycles", 0, 144'(lds), 144'(1));
        check("single_busy_cycles", 0, 144'(bsy), 144'(8));

        // early in_last on byte 6
        fill_rand(0);
        send_frame(0, 6, 5, 1'b0);
        observe(0, 4, lds, bsy, ers);
        check("early_err_pulses", 0, 144'(ers), 144'(1));
        check("early_no_load", 0, 144'(lds), 144'(0));
        check("early_keeps_A00", 0, 144'(d_out[0][0]), 144'(8'h24));
        fill_rand(0);
        send_frame(0, 18, 17, 1'b0);
        check("after_early_frame", 0, pack_dut(0), pack_model(0));
        check("after_early_A00", 0, 144'(d_out[0][0]), 144'(fb[0][0]));
        observe(0, 12, lds, bsy, ers);

        // missing in_last
        fill_rand(0);
        send_frame(0, 18, -1, 1'b0);
        observe(0, 4, lds, bsy, ers);
        check("missing_err_pulses", 0, 144'(ers), 144'(1));
        check("missing_no_load", 0, 144'(lds), 144'(0));
        fill_rand(0);
        fb[0][0] = 8'h5A;
        send_frame(0, 18, 17, 1'b0);
        check("missing_next_is_A00", 0, 144'(d_out[0][0]), 144'(8'h5A));
        observe(0, 10, lds, bsy, ers);

        // valid gaps
        for (int r = 0; r < 3; r++) begin
            fill_rand(0);
            send_frame(0, 18, 17, 1'b1);
            for (int i = 0; i < 18; i++)
                check("gap_element", 0, 144'(d_out[0][i]), 144'(fb[0][i]));
        end
        observe(0, 10, lds, bsy, ers);

        // reset after byte 10
        fill_rand(0);
        send_frame(0, 10, -1, 1'b0);
        reset_pulse(0);
        fill_rand(0);
        send_frame(0, 18, 17, 1'b1);
        check("post_reset_frame", 0, pack_dut(0), pack_model(0));
        observe(0, 3, lds, bsy, ers);

        // reset mid-hold (the frame above is still in its hold window)
        reset_pulse(0);
        fill_rand(0);
        send_frame(0, 18, 17, 1'b0);
        for (int i = 0; i < 18; i++)
            check("post_hold_reset_element", 0, 144'(d_out[0][i]), 144'(fb[0][i]));
        observe(0, 10, lds, bsy, ers);
    endtask

    task automatic run_dut1();
        int lds, bsy, ers;
        logic [7:0] first [18];
        fill_rand(1);
        send_frame(1, 18, 17, 1'b0);
        for (int i = 0; i < 18; i++) first[i] = fb[1][i];
        fill_rand(1);
        send_frame(1, 17, -1, 1'b0);
        for (int i = 0; i < 18; i++)
            check("prefetch_keeps_first", 1, 144'(d_out[1][i]), 144'(first[i]));
        send_byte(1, fb[1][17], 1'b1, 1'b0);
        for (int i = 0; i < 18; i++)
            check("second_frame_element", 1, 144'(d_out[1][i]), 144'(fb[1][i]));
        observe(1, 40, lds, bsy, ers);
        check("b2b_load_count", 1, 144'(load_t1.size()), 144'(2));
        check("b2b_final_stalled", 1, 144'(stall1 > 0), 144'(1));
        if (load_t1.size() >= 2)
            check("b2b_load_gap_min", 1, 144'(load_t1[1] - load_t1[0] >= int'(HOLD1)), 144'(1));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]     = 1'b1;
            v_data[k]  = 8'h00;
            v_valid[k] = 1'b0;
            v_last[k]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 0, pack_dut(0), '0);
        check("reset_ctl", 0, 144'({d_load[0], d_busy[0], d_err[0], d_ready[0]}), '0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        fork
            run_dut0();
            run_dut1();
        join
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1);
    end

endmodule
